nf10_rr_input_arbiter: RTL

- Packet-granular round-robin arbiter that shares one 64-bit AXI4-Stream datapath between four 10G interface receive streams.
- Sits between the m_axis outputs of four nf10_10g_interface instances and the downstream user datapath (output port lookup / loopback logic).
- Once a port is granted, its whole packet passes through unbroken; packets are never interleaved.
- Fairness comes from rotating priority after every completed packet.

---
 rtl/nf10_rr_input_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/nf10_rr_input_arbiter.sv
// Packet-granular round-robin arbiter: four AXI4-Stream receive streams share one
// output stream; a granted port keeps the output until its tlast beat transfers.
module nf10_rr_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 64,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_INPUTS         = 4
) (
    input  logic                              axi_aclk,
    input  logic                              axi_resetn,

    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic                              s_axis_tvalid_0,
    output logic                              s_axis_tready_0,
    input  logic                              s_axis_tlast_0,

    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic                              s_axis_tvalid_1,
    output logic                              s_axis_tready_1,
    input  logic                              s_axis_tlast_1,

    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_2,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
    input  logic                              s_axis_tvalid_2,
    output logic                              s_axis_tready_2,
    input  logic                              s_axis_tlast_2,

    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_3,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
    input  logic                              s_axis_tvalid_3,
    output logic                              s_axis_tready_3,
    input  logic                              s_axis_tlast_3,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,

    output logic [1:0]                        grant_idx,
    output logic                              busy
);

    localparam int STRB_W = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic {IDLE, PKT} state_t;

    state_t                          state, state_next;
    logic [1:0]                      prio_ptr, prio_next;
    logic [1:0]                      grant_next;
    logic [1:0]                      pick, cand;
    logic                            found;

    logic [C_M_AXIS_DATA_WIDTH-1:0]  tdata_arr [C_NUM_INPUTS];
    logic [STRB_W-1:0]               tstrb_arr [C_NUM_INPUTS];
    logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser_arr [C_NUM_INPUTS];
    logic [C_NUM_INPUTS-1:0]         valid_vec, last_vec, ready_vec;

    assign tdata_arr[0] = s_axis_tdata_0;
    assign tdata_arr[1] = s_axis_tdata_1;
    assign tdata_arr[2] = s_axis_tdata_2;
    assign tdata_arr[3] = s_axis_tdata_3;
    assign tstrb_arr[0] = s_axis_tstrb_0;
    assign tstrb_arr[1] = s_axis_tstrb_1;
    assign tstrb_arr[2] = s_axis_tstrb_2;
    assign tstrb_arr[3] = s_axis_tstrb_3;
    assign tuser_arr[0] = s_axis_tuser_0;
    assign tuser_arr[1] = s_axis_tuser_1;
    assign tuser_arr[2] = s_axis_tuser_2;
    assign tuser_arr[3] = s_axis_tuser_3;
    assign valid_vec    = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign last_vec     = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

    assign s_axis_tready_0 = ready_vec[0];
    assign s_axis_tready_1 = ready_vec[1];
    assign s_axis_tready_2 = ready_vec[2];
    assign s_axis_tready_3 = ready_vec[3];

    assign busy = (state == PKT);

    // Rotating-priority search: first requester at or after prio_ptr, wrapping mod 4.
    always_comb begin
        pick  = prio_ptr;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < C_NUM_INPUTS; k++) begin
            cand = prio_ptr + 2'(k);
            if (!found && valid_vec[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Output mux: the granted port is wired straight through while in PKT.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        ready_vec     = '0;
        if (state == PKT) begin
            m_axis_tdata         = tdata_arr[grant_idx];
            m_axis_tstrb         = tstrb_arr[grant_idx];
            m_axis_tuser         = tuser_arr[grant_idx];
            m_axis_tvalid        = valid_vec[grant_idx];
            m_axis_tlast         = last_vec[grant_idx];
            ready_vec[grant_idx] = m_axis_tready;
        end
    end

    always_comb begin
        state_next = state;
        prio_next  = prio_ptr;
        grant_next = grant_idx;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = PKT;
                    grant_next = pick;
                end
            end
            PKT: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_next = IDLE;
                    prio_next  = grant_idx + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            state     <= IDLE;
            prio_ptr  <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_next;
            prio_ptr  <= prio_next;
            grant_idx <= grant_next;
        end
    end

endmodule
